// File: rtl/conv_mul_share_sched.sv
// Round-robin scheduler sharing one signed 16x8 MAC among NUM_REQ requesters.
// Three-stage pipeline: operand capture, product, per-requester accumulate.
// The whole pipeline freezes while a finished result waits for the consumer.
module conv_mul_share_sched #(
    parameter int NUM_REQ   = 4,
    parameter int ACC_WIDTH = 32,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [16*NUM_REQ-1:0]  req_a,
    input  logic [8*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ID_W-1:0]        res_id,
    output logic [ACC_WIDTH-1:0]   res_data,
    output logic                   idle
);

    logic                        adv;
    logic                        gnt_any;
    logic [ID_W-1:0]             gnt_id;
    logic [ID_W-1:0]             rr_idx;
    logic                        xfer;
    logic [ID_W-1:0]             ptr_q;

    logic                        s1_vld_q, s1_last_q;
    logic [ID_W-1:0]             s1_id_q;
    logic signed [15:0]          s1_a_q;
    logic signed [7:0]           s1_b_q;

    logic                        s2_vld_q, s2_last_q;
    logic [ID_W-1:0]             s2_id_q;
    logic signed [23:0]          s2_p_q;

    logic signed [ACC_WIDTH-1:0] acc_q [NUM_REQ];
    logic signed [ACC_WIDTH-1:0] acc_sum_d;

    logic                        res_valid_q;
    logic [ID_W-1:0]             res_id_q;
    logic [ACC_WIDTH-1:0]        res_data_q;

    // A held result blocks every stage, so nothing can overtake it.
    assign adv  = !(res_valid_q && !res_ready);
    assign xfer = adv && gnt_any && !ap_rst;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        rr_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_any && req_valid[rr_idx]) begin
                gnt_any = 1'b1;
                gnt_id  = rr_idx;
            end
        end
    end

    // Grant is one-hot and suppressed during stall and reset.
    always_comb begin
        req_ready = '0;
        if (xfer) req_ready[gnt_id] = 1'b1;
    end

    // S1: capture the granted operand beat; pointer moves only on a transfer.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ptr_q     <= ID_W'(NUM_REQ - 1);
            s1_vld_q  <= 1'b0;
            s1_last_q <= 1'b0;
            s1_id_q   <= '0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
        end else if (adv) begin
            s1_vld_q  <= xfer;
            s1_last_q <= req_last[gnt_id];
            s1_id_q   <= gnt_id;
            s1_a_q    <= req_a[16*gnt_id +: 16];
            s1_b_q    <= req_b[8*gnt_id +: 8];
            if (xfer) ptr_q <= gnt_id;
        end
    end

    // S2: full-precision signed product (16x8 always fits in 24 bits).
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            s2_vld_q  <= 1'b0;
            s2_last_q <= 1'b0;
            s2_id_q   <= '0;
            s2_p_q    <= '0;
        end else if (adv) begin
            s2_vld_q  <= s1_vld_q;
            s2_last_q <= s1_last_q;
            s2_id_q   <= s1_id_q;
            s2_p_q    <= 24'(s1_a_q) * 24'(s1_b_q);
        end
    end

    // Sign-extended product added to the owning requester's running sum.
    assign acc_sum_d = acc_q[s2_id_q] + ACC_WIDTH'(s2_p_q);

    // S3: accumulate, or retire a dot product into the result register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            for (int i = 0; i < NUM_REQ; i++) acc_q[i] <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_data_q  <= '0;
        end else begin
            if (res_valid_q && res_ready) res_valid_q <= 1'b0;
            // A new load in the same cycle as acceptance wins.
            if (adv && s2_vld_q) begin
                if (s2_last_q) begin
                    acc_q[s2_id_q] <= '0;
                    res_valid_q    <= 1'b1;
                    res_id_q       <= s2_id_q;
                    res_data_q     <= acc_sum_d;
                end else begin
                    acc_q[s2_id_q] <= acc_sum_d;
                end
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_data  = res_data_q;
    assign idle      = !s1_vld_q && !s2_vld_q && !res_valid_q;

endmodule
